// File: rtl/rfilt_pkg.sv
// Shared definitions for the range-weighted window filter: datapath width helpers,
// the weight-squaring step and the stage/divider state types.
package rfilt_pkg;

    typedef logic stage_valid_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_RUN,
        DIV_DONE
    } div_state_t;

    function automatic int num_w(input int pix_w, input int taps);
        return 2 * pix_w + $clog2(taps);
    endfunction

    function automatic int den_w(input int pix_w, input int taps);
        return pix_w + $clog2(taps);
    endfunction

    // One squaring step: w <= (w*w) >> pix_w; the caller truncates to pix_w bits.
    function automatic logic [63:0] sq_weight(input logic [31:0] w, input int pix_w);
        return ({32'd0, w} * {32'd0, w}) >> pix_w;
    endfunction

endpackage

// File: rtl/rfilt_seq_div.sv
// Start/done restoring divider producing one quotient bit per cycle (QW cycles per divide).
// Define RANGE_FILTER_ROUND_EN for round-half-up quotients; otherwise the quotient truncates.
module rfilt_seq_div
    import rfilt_pkg::*;
#(
    parameter int NW = 20,
    parameter int DW = 12,
    parameter int QW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [NW-1:0] num,
    input  logic [DW-1:0] den,
    input  logic          take,
    output logic          free,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quot
);

    localparam int CW    = (NW + 1 > DW + QW + 1) ? NW + 1 : DW + QW + 1;
    localparam int CNT_W = $clog2(QW + 1);
`ifdef RANGE_FILTER_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CW-1:0]    rem, dsh, rem_init;
    logic [QW-1:0]    q;
    logic             ovf;
    logic             ge;

    assign rem_init = CW'(num) + (ROUND ? CW'(den >> 1) : CW'(0));
    assign ge       = (rem >= dsh);
    assign done     = (state == DIV_DONE);
    assign busy     = (state != DIV_IDLE);
    // A finished result leaving this cycle frees the divider for an immediate reload.
    assign free     = (state == DIV_IDLE) || (done && take);
    assign quot     = ovf ? '1 : q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: if (start) state_nxt = DIV_RUN;
            DIV_RUN:  if (cnt == '0) state_nxt = DIV_DONE;
            DIV_DONE: if (take) state_nxt = start ? DIV_RUN : DIV_IDLE;
            default:  state_nxt = DIV_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DIV_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: datapath registers carry no reset; the state machine guards every use of them.
    always_ff @(posedge clk) begin
        if (start) begin
            rem <= rem_init;
            dsh <= CW'(den) << (QW - 1);
            q   <= '0;
            cnt <= CNT_W'(QW - 1);
            ovf <= (rem_init >= (CW'(den) << QW));
        end else if (state == DIV_RUN) begin
            if (ge) rem <= rem - dsh;
            dsh <= dsh >> 1;
            q   <= (q << 1) | QW'(ge);
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/range_filter_pipe.sv
// Range-weighted window filter: weight pipeline, product/sum stages, iterative divider, output register.
// Rounding mode is selected by the RANGE_FILTER_ROUND_EN macro inside rfilt_seq_div.
module range_filter_pipe
    import rfilt_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int TAPS      = 9,
    parameter int SQ_STAGES = 3,
    parameter int CENTER_W  = 248
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [TAPS*PIX_W-1:0]   in_pixels,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PIX_W-1:0]        out_pixel,
    output logic                    busy
);

    localparam int C   = TAPS / 2;
    localparam int NW  = num_w(PIX_W, TAPS);
    localparam int DW  = den_w(PIX_W, TAPS);
    localparam int PW2 = 2 * PIX_W;
    localparam int PS  = SQ_STAGES + 1;
    localparam int SS  = SQ_STAGES + 2;
    localparam int NS  = SQ_STAGES + 3;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;
    localparam logic [PIX_W-1:0] CTR_W   = PIX_W'(CENTER_W);

    if (CENTER_W < 1 || CENTER_W > (2 ** PIX_W) - 1) begin : g_bad_center
        $error("range_filter_pipe: CENTER_W out of range");
    end
    if (TAPS < 3 || (TAPS % 2) == 0) begin : g_bad_taps
        $error("range_filter_pipe: TAPS must be odd and >= 3");
    end
    if (SQ_STAGES < 1) begin : g_bad_sq
        $error("range_filter_pipe: SQ_STAGES must be >= 1");
    end

    stage_valid_t [NS-1:0]   vld;
    logic [NS-1:0]           adv;
    logic [TAPS*PIX_W-1:0]   pix0, w0, w_last, pix_last, wp_q;
    logic [TAPS*PW2-1:0]     prod_nxt, prod_q;
    logic [NW-1:0]           num_nxt, num_q;
    logic [DW-1:0]           den_nxt, den_q;
    logic                    div_free, div_busy, div_done, div_take;
    logic [PIX_W-1:0]        div_quot;

    // Initial weights from absolute distance to the centre pixel.
    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            logic [PIX_W-1:0] p, pc, d;
            p  = pix0[i*PIX_W +: PIX_W];
            pc = pix0[C*PIX_W +: PIX_W];
            d  = (p > pc) ? p - pc : pc - p;
            w0[i*PIX_W +: PIX_W] = (i == C) ? CTR_W : PIX_MAX - d;
        end
    end

    for (genvar k = 1; k <= SQ_STAGES; k++) begin : g_sq
        logic [TAPS*PIX_W-1:0] src_w, src_pix, nxt, w, pix;
        if (k == 1) begin : g_first
            assign src_w   = w0;
            assign src_pix = pix0;
        end else begin : g_rest
            assign src_w   = g_sq[k-1].w;
            assign src_pix = g_sq[k-1].pix;
        end
        always_comb begin
            for (int i = 0; i < TAPS; i++) begin
                nxt[i*PIX_W +: PIX_W] = (i == C) ? CTR_W
                    : PIX_W'(sq_weight(32'(src_w[i*PIX_W +: PIX_W]), PIX_W));
            end
        end
        always_ff @(posedge clk) begin
            if (adv[k-1]) begin
                w   <= nxt;
                pix <= src_pix;
            end
        end
    end

    assign w_last   = g_sq[SQ_STAGES].w;
    assign pix_last = g_sq[SQ_STAGES].pix;

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            prod_nxt[i*PW2 +: PW2] = PW2'(w_last[i*PIX_W +: PIX_W]) * PW2'(pix_last[i*PIX_W +: PIX_W]);
        end
    end

    always_comb begin
        num_nxt = '0;
        den_nxt = '0;
        for (int i = 0; i < TAPS; i++) begin
            num_nxt = num_nxt + NW'(prod_q[i*PW2 +: PW2]);
            den_nxt = den_nxt + DW'(wp_q[i*PIX_W +: PIX_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) pix0 <= in_pixels;
        if (adv[SQ_STAGES]) begin
            prod_q <= prod_nxt;
            wp_q   <= w_last;
        end
        if (adv[PS]) begin
            num_q <= num_nxt;
            den_q <= den_nxt;
        end
    end

    // Advance enables ripple back from the divider: a stage moves when its successor is empty or moving.
    always_comb begin
        logic go, a;
        go  = div_free;
        adv = '0;
        for (int k = SS; k >= 0; k--) begin
            a      = vld[k] & go;
            adv[k] = a;
            go     = !vld[k] | a;
        end
    end

    assign in_ready = !vld[0] | adv[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld[0] <= (in_valid & in_ready) | (vld[0] & !adv[0]);
            for (int k = 1; k < NS; k++) vld[k] <= adv[k-1] | (vld[k] & !adv[k]);
        end
    end

    assign div_take = div_done && (!out_valid || out_ready);

    rfilt_seq_div #(
        .NW (NW),
        .DW (DW),
        .QW (PIX_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (adv[SS]),
        .num   (num_q),
        .den   (den_q),
        .take  (div_take),
        .free  (div_free),
        .busy  (div_busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else if (div_take) begin
            out_valid <= 1'b1;
            out_pixel <= div_quot;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = (|vld) | div_busy | out_valid;

endmodule
